// File: rtl/acondicionador_botones_pkg.sv
// Shared types and default timing constants for the button conditioner.
package acondicionador_botones_pkg;

    // Per-button repeat sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } estado_t;

    // Defaults for a 100 MHz clock: 10 ms debounce, 500 ms hold, 100 ms repeat.
    localparam int unsigned DEB_CYC_DEF  = 1000000;
    localparam int unsigned HOLD_CYC_DEF = 50000000;
    localparam int unsigned REP_CYC_DEF  = 10000000;
    localparam int unsigned CNT_W_DEF    = 26;

endpackage

// File: rtl/acondicionador_botones_antirrebote.sv
// One button channel: 2-flop synchroniser, debouncer and rising-edge flag.
// The edge flag is registered alongside estable so both change on the same edge.
module antirrebote
    import acondicionador_botones_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic estable,
    output logic sube
);

    logic             sync1_q, sync2_q;
    logic             estable_q, estable_d;
    logic             sube_q, sube_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: count consecutive cycles of disagreement, toggle on the last one.
    always_comb begin
        estable_d = estable_q;
        cnt_d     = '0;
        if (sync2_q != estable_q) begin
            if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                estable_d = ~estable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        sube_d = estable_d & ~estable_q;
    end

    // Synchroniser chain and debouncer state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            estable_q <= 1'b0;
            sube_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            estable_q <= estable_d;
            sube_q    <= sube_d;
            cnt_q     <= cnt_d;
        end
    end

    assign estable = estable_q;
    assign sube    = sube_q;

endmodule

// File: rtl/acondicionador_botones.sv
// Button conditioner top: two debounced channels, per-button press/auto-repeat
// sequencers and mutual exclusion between the two buttons.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a fresh debounced press
// ST_HOLD   | press accepted, counting down to the first repeat pulse
// ST_REPEAT | auto-repeat, one pulse every REP_CYC cycles
//
// While both buttons are held the sequencers freeze with counters cleared.
// On the cycle after the lock ends, the button still held restarts in
// ST_HOLD with a full hold count, as if it had just been pressed, but
// without the press pulse.
module acondicionador_botones
    import acondicionador_botones_pkg::*;
#(
    parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
    parameter int unsigned REP_CYC  = REP_CYC_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_raw,
    input  logic       EN,
    output logic [1:0] botones,
    output logic [1:0] estable
);

    logic [1:0]       estable_w, sube_w;
    estado_t          estado_q [2];
    estado_t          estado_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             bloqueo_q, bloqueo_d;
    logic [1:0]       botones_q, botones_d;
    logic [1:0]       pulso;

    for (genvar g = 0; g < 2; g++) begin : g_canal
        antirrebote #(
            .DEB_CYC (DEB_CYC),
            .CNT_W   (CNT_W)
        ) u_antirrebote (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[g]),
            .estable (estable_w[g]),
            .sube    (sube_w[g])
        );
    end

    // Sequencer next-state and pulse generation, in priority order:
    // disable/release, both-held lock, lock exit, normal press/repeat.
    always_comb begin
        bloqueo_d = estable_w[0] & estable_w[1];
        pulso     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            estado_d[i] = estado_q[i];
            cnt_d[i]    = cnt_q[i];
            if (!EN || !estable_w[i]) begin
                estado_d[i] = ST_IDLE;
                cnt_d[i]    = '0;
            end else if (bloqueo_d) begin
                cnt_d[i]    = '0;
            end else if (bloqueo_q) begin
                estado_d[i] = ST_HOLD;
                cnt_d[i]    = CNT_W'(HOLD_CYC - 1);
            end else begin
                case (estado_q[i])
                    ST_IDLE: begin
                        if (sube_w[i]) begin
                            pulso[i]    = 1'b1;
                            estado_d[i] = ST_HOLD;
                            cnt_d[i]    = CNT_W'(HOLD_CYC - 1);
                        end
                    end
                    ST_HOLD, ST_REPEAT: begin
                        if (cnt_q[i] == '0) begin
                            pulso[i]    = 1'b1;
                            estado_d[i] = ST_REPEAT;
                            cnt_d[i]    = CNT_W'(REP_CYC - 1);
                        end else begin
                            cnt_d[i]    = cnt_q[i] - CNT_W'(1);
                        end
                    end
                    default: begin
                        estado_d[i] = ST_IDLE;
                        cnt_d[i]    = '0;
                    end
                endcase
            end
        end
        botones_d = (pulso == 2'b11) ? 2'b00 : pulso;
    end

    // Sequencer state, counters, lock history and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                estado_q[i] <= ST_IDLE;
                cnt_q[i]    <= '0;
            end
            bloqueo_q <= 1'b0;
            botones_q <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                estado_q[i] <= estado_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            bloqueo_q <= bloqueo_d;
            botones_q <= botones_d;
        end
    end

    assign botones = botones_q;
    assign estable = estable_w;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones with short timing constants.
// Expected pulses (cycle, value) are queued when stimulus is applied and
// matched by a monitor whenever botones is non-zero.
module tb_acondicionador_botones;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 20;
    localparam int unsigned REP  = 8;

    logic       clk;
    logic       rst;
    logic [1:0] btn_raw;
    logic       en;
    logic [1:0] botones;
    logic [1:0] estable;

    typedef struct {
        int         ciclo;
        logic [1:0] valor;
    } pulso_t;

    pulso_t sb[$];
    int     cyc;
    int     n_eval;
    int     n_fail;

    acondicionador_botones #(
        .DEB_CYC  (DEB),
        .HOLD_CYC (HOLD),
        .REP_CYC  (REP),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .EN      (en),
        .botones (botones),
        .estable (estable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after rising edge k (and until the next), cyc == k.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic verificar(input string tag, input int obs, input int esp);
        n_eval++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, esp, cyc);
        end
    endtask

    task automatic esperar(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic aplicar(input logic [1:0] v, output int t);
        @(posedge clk);
        #1;
        btn_raw = v;
        t = cyc;
    endtask

    task automatic esperar_pulso(input int ciclo, input logic [1:0] v);
        pulso_t p;
        p.ciclo = ciclo;
        p.valor = v;
        sb.push_back(p);
    endtask

    // Monitor: every non-zero botones sample must match the queue head.
    always @(negedge clk) begin
        if (botones !== 2'b00) begin
            if (sb.size() == 0) begin
                verificar("pulso_inesperado", int'(botones), 0);
            end else begin
                pulso_t p;
                p = sb.pop_front();
                verificar("pulso_ciclo", cyc, p.ciclo);
                verificar("pulso_valor", int'(botones), int'(p.valor));
            end
        end
    end

    initial begin
        int t0, t1, t2, t3, tx;
        n_eval  = 0;
        n_fail  = 0;
        rst     = 1'b0;
        btn_raw = 2'b00;
        en      = 1'b1;

        // Reset and idle.
        #100;
        verificar("rst_botones", int'(botones), 0);
        verificar("rst_estable", int'(estable), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        verificar("idle_estable", int'(estable), 0);

        // Single press of bit 1, released before the hold expires.
        aplicar(2'b10, t0);
        esperar_pulso(t0 + 7, 2'b10);
        esperar(t0 + 5);
        verificar("deb_antes", int'(estable), 0);
        esperar(t0 + 6);
        verificar("deb_sube", int'(estable), 2);
        esperar(t0 + 14);
        aplicar(2'b00, t1);
        esperar(t1 + 5);
        verificar("suelta_antes", int'(estable), 2);
        esperar(t1 + 6);
        verificar("suelta_baja", int'(estable), 0);
        esperar(t1 + 20);
        verificar("sb_simple", sb.size(), 0);

        // 3-cycle glitch bursts on bit 0 never pass the debouncer.
        for (int k = 0; k < 10; k++) begin
            aplicar((k % 2 == 0) ? 2'b01 : 2'b00, tx);
            esperar(tx + 2);
            verificar("glitch_estable", int'(estable), 0);
        end
        aplicar(2'b00, tx);
        esperar(tx + 10);
        verificar("glitch_fin", int'(estable), 0);

        // Bit 0 held 60 cycles: press pulse then auto-repeat.
        aplicar(2'b01, t0);
        esperar_pulso(t0 + 7, 2'b01);
        esperar_pulso(t0 + 7 + HOLD, 2'b01);
        for (int k = 1; k <= 4; k++) esperar_pulso(t0 + 7 + HOLD + k * REP, 2'b01);
        esperar(t0 + 6);
        verificar("rep_estable", int'(estable), 1);
        esperar(t0 + 59);
        aplicar(2'b00, t1);
        esperar(t1 + 15);
        verificar("sb_repeat", sb.size(), 0);

        // Both pressed together: locked out. Dropping bit 1 restarts bit 0
        // in hold on the cycle after estable[1] falls (edge t1+7).
        aplicar(2'b11, t0);
        esperar(t0 + 6);
        verificar("ambos_estable", int'(estable), 3);
        esperar(t0 + 39);
        aplicar(2'b01, t1);
        esperar_pulso(t1 + 7 + HOLD, 2'b01);
        esperar_pulso(t1 + 7 + HOLD + REP, 2'b01);
        esperar(t1 + 6);
        verificar("ambos_suelta1", int'(estable), 1);
        esperar(t1 + 31);
        aplicar(2'b00, t2);
        esperar(t2 + 15);
        verificar("sb_ambos", sb.size(), 0);

        // EN dropped during repeat: no pulses while low nor after reassertion.
        aplicar(2'b10, t0);
        esperar_pulso(t0 + 7, 2'b10);
        esperar_pulso(t0 + 7 + HOLD, 2'b10);
        esperar(t0 + 29);
        @(posedge clk);
        #1;
        en = 1'b0;
        esperar(t0 + 40);
        verificar("en_estable", int'(estable), 2);
        esperar(t0 + 49);
        @(posedge clk);
        #1;
        en = 1'b1;
        esperar(t0 + 79);
        aplicar(2'b00, t1);
        esperar(t1 + 10);
        verificar("en_suelta", int'(estable), 0);
        verificar("sb_en", sb.size(), 0);

        // Reset mid-hold clears outputs at once; a button held through
        // reset release gives one normal press pulse after debounce.
        aplicar(2'b10, t2);
        esperar_pulso(t2 + 7, 2'b10);
        esperar(t2 + 14);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        verificar("rst_mid_botones", int'(botones), 0);
        verificar("rst_mid_estable", int'(estable), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        t3 = cyc;
        esperar_pulso(t3 + 7, 2'b10);
        esperar(t3 + 6);
        verificar("rst_redeb", int'(estable), 2);
        esperar(t3 + 10);
        aplicar(2'b00, tx);
        esperar(tx + 12);
        verificar("rst_fin_estable", int'(estable), 0);

        verificar("sb_vacio", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
